// File: rtl/inst_fetch_unit.sv
// Fetch stage: owns the PC, drives a 1-cycle synchronous instruction memory, holds IF/ID.
// Stalls hold PC and IF/ID; branch redirects refill through FILL, giving two bubbles.
module inst_fetch_unit #(
  parameter int                ADDR_W   = 32,
  parameter int                INST_W   = 32,
  parameter int                HEADER_W = 10,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int                PC_STEP  = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                stall,
  input  logic                branch_taken,
  input  logic [ADDR_W-1:0]   branch_target,
  output logic [ADDR_W-1:0]   imem_addr,
  output logic                imem_rd_en,
  input  logic [INST_W-1:0]   imem_rdata,
  output logic [INST_W-1:0]   inst_out,
  output logic [HEADER_W-1:0] inst_head,
  output logic [ADDR_W-1:0]   pc_out,
  output logic [ADDR_W-1:0]   pc_link,
  output logic                inst_valid
);

  typedef enum logic [1:0] {FILL, RUN, HOLD} state_t;

  localparam logic [ADDR_W-1:0] STEP = ADDR_W'(PC_STEP);

  state_t            state, nxt_state;
  logic [ADDR_W-1:0] pc, rd_pc;
  logic              capture, advance;

  always_comb begin
    nxt_state  = state;
    imem_rd_en = 1'b0;
    capture    = 1'b0;
    advance    = 1'b0;
    case (state)
      FILL: begin
        imem_rd_en = 1'b1;
        advance    = 1'b1;
        nxt_state  = RUN;
      end
      RUN: begin
        if (stall) begin
          nxt_state = HOLD;
        end else begin
          imem_rd_en = 1'b1;
          capture    = 1'b1;
          advance    = 1'b1;
        end
      end
      HOLD: begin
        // Memory kept the stalled word on rdata, so release can capture it and fetch ahead at once.
        if (!stall) begin
          imem_rd_en = 1'b1;
          capture    = 1'b1;
          advance    = 1'b1;
          nxt_state  = RUN;
        end
      end
      default: nxt_state = FILL;
    endcase
    if (branch_taken) begin
      capture   = 1'b0;
      nxt_state = FILL;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= FILL;
      pc         <= RESET_PC;
      rd_pc      <= RESET_PC;
      inst_out   <= '0;
      inst_valid <= 1'b0;
      pc_out     <= RESET_PC;
      pc_link    <= RESET_PC + STEP;
    end else begin
      state <= nxt_state;
      if (imem_rd_en) rd_pc <= pc;
      if (branch_taken)  pc <= branch_target;
      else if (advance)  pc <= pc + STEP;
      if (branch_taken || state == FILL) begin
        inst_out   <= '0;
        inst_valid <= 1'b0;
      end else if (capture) begin
        inst_out   <= imem_rdata;
        inst_valid <= 1'b1;
        pc_out     <= rd_pc;
        pc_link    <= rd_pc + STEP;
      end
    end
  end

  assign imem_addr = pc;
  assign inst_head = inst_out[INST_W-1 -: HEADER_W];

endmodule
